// File: rtl/dvr_chan_fifo_pkg.sv
// Shared constants for the DVR channel FIFO block: default channel numbers
// (kept in one place so top-level decode and host software agree) and decode types.
package dvr_chan_fifo_pkg;

    localparam logic [6:0] DVR_CHAN_FIFO_DATA  = 7'd10;
    localparam logic [6:0] DVR_CHAN_FIFO_STAT  = 7'd11;
    localparam int         DVR_CHAN_FIFO_WIDTH = 8;

    typedef enum logic [1:0] {
        SEL_DATA,
        SEL_STAT,
        SEL_OTHER
    } chanSel_e;

endpackage

// File: rtl/dvr_chan_fifo_fifo_sync.sv
// First-word-fall-through synchronous FIFO with a count output and a
// synchronous flush that overrides any push or pop in the same cycle.
module fifo_sync #(
    parameter int DEPTH_LOG2 = 4,
    parameter int WIDTH      = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  flush,
    input  logic [WIDTH-1:0]      pushData,
    input  logic                  pushValid,
    output logic                  pushReady,
    output logic [WIDTH-1:0]      popData,
    input  logic                  popReady,
    output logic [DEPTH_LOG2:0]   count
);

    localparam int                  DEPTH    = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0] FULL_CNT = (DEPTH_LOG2 + 1)'(DEPTH);

    logic [WIDTH-1:0]      mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wrPtr;
    logic [DEPTH_LOG2-1:0] rdPtr;
    logic                  full;
    logic                  empty;
    logic                  doPush;
    logic                  doPop;

    // Push and pop are judged on the pre-edge count, so there is no bypass
    // through a full or an empty FIFO.
    assign full      = (count == FULL_CNT);
    assign empty     = (count == '0);
    assign pushReady = !full;
    assign doPush    = pushValid && !full && !flush;
    assign doPop     = popReady && !empty && !flush;
    assign popData   = mem[rdPtr];

    always_ff @(posedge clk) begin
        if (doPush) mem[wrPtr] <= pushData;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else if (flush) begin
            wrPtr <= '0;
            rdPtr <= '0;
            count <= '0;
        end else begin
            if (doPush) wrPtr <= wrPtr + 1'b1;
            if (doPop)  rdPtr <= rdPtr + 1'b1;
            case ({doPush, doPop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/dvr_chan_fifo.sv
// Buffers the host DVR channel: host writes land in an RX FIFO for the app, app
// data in a TX FIFO is read back by the host; the status channel reports RX fill and flushes.
module dvr_chan_fifo
    import dvr_chan_fifo_pkg::*;
#(
    parameter logic [6:0] CHAN_ADDR  = DVR_CHAN_FIFO_DATA,
    parameter logic [6:0] STAT_ADDR  = DVR_CHAN_FIFO_STAT,
    parameter int         DEPTH_LOG2 = 4
) (
    input  logic       clk_in,
    input  logic       reset_in,
    input  logic [6:0] chanAddr_in,
    input  logic [7:0] h2fData_in,
    input  logic       h2fValid_in,
    output logic       h2fReady_out,
    output logic [7:0] f2hData_out,
    output logic       f2hValid_out,
    input  logic       f2hReady_in,
    output logic [7:0] appRxData_out,
    output logic       appRxValid_out,
    input  logic       appRxReady_in,
    input  logic [7:0] appTxData_in,
    input  logic       appTxValid_in,
    output logic       appTxReady_out
);

    chanSel_e              sel;
    logic                  flush;
    logic                  rxReady;
    logic [DEPTH_LOG2:0]   rxCount;
    logic [DEPTH_LOG2:0]   txCount;
    logic [7:0]            txHead;
    logic                  txEmpty;

    always_comb begin
        sel = SEL_OTHER;
        if (chanAddr_in == CHAN_ADDR)      sel = SEL_DATA;
        else if (chanAddr_in == STAT_ADDR) sel = SEL_STAT;
    end

    assign flush          = (sel == SEL_STAT) && h2fValid_in;
    assign appRxValid_out = (rxCount != '0);
    assign txEmpty        = (txCount == '0);

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(DVR_CHAN_FIFO_WIDTH)) rxFifo (
        .clk       (clk_in),
        .rst_n     (reset_in),
        .flush     (flush),
        .pushData  (h2fData_in),
        .pushValid ((sel == SEL_DATA) && h2fValid_in),
        .pushReady (rxReady),
        .popData   (appRxData_out),
        .popReady  (appRxReady_in),
        .count     (rxCount)
    );

    fifo_sync #(.DEPTH_LOG2(DEPTH_LOG2), .WIDTH(DVR_CHAN_FIFO_WIDTH)) txFifo (
        .clk       (clk_in),
        .rst_n     (reset_in),
        .flush     (flush),
        .pushData  (appTxData_in),
        .pushValid (appTxValid_in),
        .pushReady (appTxReady_out),
        .popData   (txHead),
        .popReady  ((sel == SEL_DATA) && f2hReady_in),
        .count     (txCount)
    );

    // Ready is only throttled on the data channel; writes elsewhere are
    // either flushes or belong to another channel owner.
    always_comb begin
        h2fReady_out = 1'b1;
        f2hValid_out = 1'b0;
        f2hData_out  = 8'h00;
        case (sel)
            SEL_DATA: begin
                h2fReady_out = rxReady;
                f2hValid_out = !txEmpty;
                f2hData_out  = txHead;
            end
            SEL_STAT: begin
                f2hValid_out = 1'b1;
                f2hData_out  = 8'(rxCount);
            end
            default: ;
        endcase
    end

endmodule
